bomb_scheduler: RTL
===================

# bomb_scheduler

Bomb lifecycle controller between the two player input paths and the blast/health logic. It arbitrates bomb-placement requests from player A and player B onto a single slot-table write port. It runs per-bomb fuse timers off the 1 Hz bomb tick and sequences detonations one at a time to the blast unit over a valid/ack handshake. It also publishes the pending-bomb occupancy of the 10x10 arena for the movement and VGA logic.

## Interface
- FUSE_TICKS, 3, fuse length in bomb ticks (1..15)
- SLOTS, 2, bombs each player may have pending (1..4); the table holds 2*SLOTS entries, with A in indices 0..SLOTS-1 and B in indices SLOTS..2*SLOTS-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle bomb-clock enable pulse
- halt  in  1  game over / freeze
- reqA_v, reqB_v  in  1  placement request; held until ready
- reqA_x, reqA_y, reqB_x, reqB_y  in  4  request cell; valid range 0..9
- reqA_rdy, reqB_rdy  out  1  request consumed this cycle
- det_v  out  1  detonation pending
- det_x, det_y  out  4  detonating cell
- det_owner  out  1  0 = A, 1 = B
- det_ack  in  1  blast unit has taken the detonation
- activeA, activeB  out  3  pending-bomb count per player
- occ_map  out  100  bit y*10+x set while any valid slot holds that cell

## Operation
- Slot contents:
  - valid
  - x, y
  - fuse (4 bits)
  - expired flag
- Request eligibility. eligibleP = reqP_v & !halt & (free slot for P) & (cell not in occ_map).
  - All terms use registered state.
- Out-of-range request (x>9 or y>9) with !halt:
  - rdy pulses for one cycle.
  - The request is dropped; no slot is written.
- Arbitration:
  - If only one player is eligible, that player is granted.
  - If both are eligible, the player named by the prio register is granted; prio then flips to the loser.
  - prio is unchanged when only one player is granted.
  - The loser's rdy stays 0, and it retries next cycle.
  - If both players requested the same cell, the loser becomes ineligible because the cell is now occupied.
- Grant effects:
  - reqP_rdy=1 combinationally in the grant cycle.
  - At the clock edge, the lowest free slot of P is loaded with valid=1, fuse=FUSE_TICKS, expired=0.
- Fuse:
  - On tick & !halt, every valid, non-expired slot decrements its fuse.
  - A fuse reaching 0 sets expired.
  - A slot loaded in the same cycle as a tick is not decremented.
  - tick while halt=1 is ignored.
- Detonation FSM:
  - IDLE: if any expired slot exists and !halt, latch the lowest expired index, then go to ISSUE.
  - ISSUE:
    - det_v=1, with det_x, det_y, det_owner taken from the latched slot and held stable.
    - On det_ack, clear the slot (valid=0, expired=0) and return to IDLE.
  - halt does not abort ISSUE; it only blocks new IDLE->ISSUE transitions.
- Counts and map:
  - activeA, activeB and occ_map are registered views of the slot table.
  - A detonating slot stays counted and stays in occ_map until its ack edge.

## Timing
- Reset (rst=0, asynchronous):
  - all slots invalid
  - FSM in IDLE
  - prio=A
  - det_v=0, det_x=det_y=0, det_owner=0
  - activeA=activeB=0
  - occ_map=0
  - These values apply immediately, including during an in-flight ISSUE.
- reqP_rdy is combinational from registered state plus reqP_v and halt.
- Placement latency:
  - occ_map and activeP update at the edge ending the grant cycle.
- Expiry latency:
  - tick cycle edge: expired=1.
  - Next cycle: FSM is in IDLE and latches.
  - The following cycle: det_v=1.
  - Detonation therefore rises 2 cycles after the final tick.
- Ack handling:
  - det_ack is sampled only while det_v=1; ack in the first ISSUE cycle is legal.
  - det_v is low for at least one cycle between detonations, giving a maximum rate of one detonation per 2 cycles.
- A slot freed by ack is placeable from the next cycle onward, never in the ack cycle.
- Simultaneous events:
  - Grant, tick and ack in the same cycle are all applied independently at the same edge.
  - Ack on slot k does not affect the fuse decrement of other slots.

## Test plan
- Reset, then A requests (3,4) for one cycle:
  - reqA_rdy=1 in that cycle.
  - Next cycle: activeA=1 and occ_map bit 43 set.
  - After 3 ticks: det_v=1 two cycles later, with (3,4), owner 0.
  - After ack: activeA=0 and bit 43 clear.
- A at (1,1) and B at (1,1) requested in the same cycle, prio=A:
  - A is granted.
  - B's rdy stays 0 while B holds its request.
  - prio=B.
- A places 2 bombs, then requests a 3rd:
  - reqA_rdy stays 0 until a detonation ack frees a slot.
  - rdy rises in the cycle after the ack.
- Bombs from A and B placed in the same cycle, ack delayed 5 cycles:
  - The A-slot detonation is issued first and held stable for 5 cycles.
  - The B detonation follows with a 1-cycle det_v gap.
- reqA with (10,2):
  - rdy pulses once.
  - activeA stays 0 and occ_map is unchanged.
- halt=1 during ISSUE with ticks continuing:
  - The current detonation completes on ack.
  - No new det_v, fuses are frozen, and requests are not granted.
- rst=0 asserted mid-ISSUE: det_v=0 immediately and all outputs are at reset values.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Bomb lifecycle controller: arbitrates placements from two players, runs fuse timers,
// and issues expired bombs one at a time to the blast unit over a valid/ack handshake.
module bomb_scheduler #(
  parameter int FUSE_TICKS = 3,
  parameter int SLOTS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        halt,
  input  logic        reqA_v,
  input  logic [3:0]  reqA_x,
  input  logic [3:0]  reqA_y,
  input  logic        reqB_v,
  input  logic [3:0]  reqB_x,
  input  logic [3:0]  reqB_y,
  output logic        reqA_rdy,
  output logic        reqB_rdy,
  output logic        det_v,
  output logic [3:0]  det_x,
  output logic [3:0]  det_y,
  output logic        det_owner,
  input  logic        det_ack,
  output logic [2:0]  activeA,
  output logic [2:0]  activeB,
  output logic [99:0] occ_map
);

  localparam int N  = 2 * SLOTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] FUSE_INIT = 4'(FUSE_TICKS);

  typedef enum logic {IDLE, ISSUE} stateT;
  stateT stateReg, stateNext;

  logic [N-1:0]  slotValid, slotExp, loadVec;
  logic [3:0]    slotX [N];
  logic [3:0]    slotY [N];
  logic [3:0]    slotFuse [N];
  logic          prioReg;  // 0: A wins a tie, 1: B wins a tie
  logic [IW-1:0] detIdxReg, freeIdxA, freeIdxB, expIdx;
  logic          freeA, freeB, anyExp, latchEn, ackFire;
  logic          inRangeA, inRangeB, eligA, eligB, grantA, grantB;
  logic [6:0]    cellA, cellB;

  function automatic logic [6:0] cellIndex(input logic [3:0] x, input logic [3:0] y);
    return ({3'b000, y} * 7'd10) + {3'b000, x};
  endfunction

  always_comb begin
    occ_map = '0;
    activeA = '0;
    activeB = '0;
    for (int i = 0; i < N; i++) begin
      if (slotValid[i]) begin
        occ_map[cellIndex(slotX[i], slotY[i])] = 1'b1;
        if (i < SLOTS) activeA = activeA + 3'd1;
        else           activeB = activeB + 3'd1;
      end
    end
  end

  // Lowest free slot per player and lowest expired slot overall.
  always_comb begin
    freeA = 1'b0; freeIdxA = '0;
    freeB = 1'b0; freeIdxB = '0;
    anyExp = 1'b0; expIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!slotValid[i] && i < SLOTS)  begin freeA = 1'b1; freeIdxA = IW'(i); end
      if (!slotValid[i] && i >= SLOTS) begin freeB = 1'b1; freeIdxB = IW'(i); end
      if (slotExp[i])                  begin anyExp = 1'b1; expIdx = IW'(i); end
    end
  end

  always_comb begin
    inRangeA = (reqA_x <= 4'd9) && (reqA_y <= 4'd9);
    inRangeB = (reqB_x <= 4'd9) && (reqB_y <= 4'd9);
    cellA    = inRangeA ? cellIndex(reqA_x, reqA_y) : 7'd0;
    cellB    = inRangeB ? cellIndex(reqB_x, reqB_y) : 7'd0;
    eligA    = reqA_v && !halt && inRangeA && freeA && !occ_map[cellA];
    eligB    = reqB_v && !halt && inRangeB && freeB && !occ_map[cellB];
    grantA   = eligA && (!eligB || !prioReg);
    grantB   = eligB && (!eligA ||  prioReg);
    // Out-of-range requests are acknowledged and dropped.
    reqA_rdy = grantA || (reqA_v && !halt && !inRangeA);
    reqB_rdy = grantB || (reqB_v && !halt && !inRangeB);
    loadVec  = '0;
    if (grantA) loadVec[freeIdxA] = 1'b1;
    if (grantB) loadVec[freeIdxB] = 1'b1;
  end

  always_comb begin
    stateNext = stateReg;
    latchEn   = 1'b0;
    ackFire   = 1'b0;
    det_v     = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (anyExp && !halt) begin
          latchEn   = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        det_v = 1'b1;
        if (det_ack) begin
          ackFire   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg  <= IDLE;
      prioReg   <= 1'b0;
      detIdxReg <= '0;
      det_x     <= '0;
      det_y     <= '0;
      det_owner <= 1'b0;
      slotValid <= '0;
      slotExp   <= '0;
      for (int i = 0; i < N; i++) begin
        slotX[i]    <= '0;
        slotY[i]    <= '0;
        slotFuse[i] <= '0;
      end
    end else begin
      stateReg <= stateNext;
      if (eligA && eligB) prioReg <= !prioReg;
      if (latchEn) begin
        detIdxReg <= expIdx;
        det_x     <= slotX[expIdx];
        det_y     <= slotY[expIdx];
        det_owner <= (int'(expIdx) >= SLOTS);
      end
      // Load, clear and decrement never target the same slot in one cycle.
      for (int i = 0; i < N; i++) begin
        if (loadVec[i]) begin
          slotValid[i] <= 1'b1;
          slotExp[i]   <= 1'b0;
          slotFuse[i]  <= FUSE_INIT;
          slotX[i]     <= (i < SLOTS) ? reqA_x : reqB_x;
          slotY[i]     <= (i < SLOTS) ? reqA_y : reqB_y;
        end else if (ackFire && detIdxReg == IW'(i)) begin
          slotValid[i] <= 1'b0;
          slotExp[i]   <= 1'b0;
        end else if (tick && !halt && slotValid[i] && !slotExp[i]) begin
          slotFuse[i] <= slotFuse[i] - 4'd1;
          if (slotFuse[i] == 4'd1) slotExp[i] <= 1'b1;
        end
      end
    end
  end

endmodule
